// File: rtl/param_fifo.sv
// Synchronous FIFO with wrap-bit pointers, occupancy flags and sticky error flags.
// FWFT selects a registered read port (0) or first-word-fall-through (1).
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     we,
  input  logic                     re,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             wr_acc;
  logic             rd_acc;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Flags derive only from registered pointers, never from this cycle's requests.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign wr_acc = we && !full && !flush;
  assign rd_acc = re && !empty && !flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      if (we && full) overflow <= 1'b1;
      if (re && empty) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Gated while empty so the output reads zero out of reset instead of stale memory.
      assign data_out = empty ? '0 : mem[rd_idx];
      assign valid    = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_idx];
        end
      end

      assign data_out = dout_q;
      assign valid    = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: fill/drain vector table plus hand sequences for
// wrap, simultaneous access, flush, async reset and the FWFT variant.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush, we, re;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  logic       fw_flush, fw_we, fw_re;
  logic [7:0] fw_din, fw_dout;
  logic       fw_valid, fw_empty, fw_full, fw_ae, fw_af, fw_ovf, fw_unf;
  logic [4:0] fw_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_fifo u_dut (
    .clk(clk), .rstn(rstn), .flush(flush), .we(we), .re(re), .data_in(data_in),
    .data_out(data_out), .valid(valid), .count(count), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  param_fifo #(.FWFT(1)) u_fw (
    .clk(clk), .rstn(rstn), .flush(fw_flush), .we(fw_we), .re(fw_re), .data_in(fw_din),
    .data_out(fw_dout), .valid(fw_valid), .count(fw_count), .empty(fw_empty), .full(fw_full),
    .almost_empty(fw_ae), .almost_full(fw_af), .overflow(fw_ovf), .underflow(fw_unf)
  );

  typedef struct {
    logic       we, re, flush;
    logic [7:0] din;
    logic [4:0] count;
    logic [7:0] dout;
    logic       valid, empty, full, af, ae, ovf, unf;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic f, input logic [7:0] d);
    @(negedge clk);
    we = w; re = r; flush = f; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".empty"}, 32'(empty), 1);
    chk({tag, ".ae"}, 32'(almost_empty), 1);
    chk({tag, ".full"}, 32'(full), 0);
    chk({tag, ".af"}, 32'(almost_full), 0);
    chk({tag, ".valid"}, 32'(valid), 0);
    chk({tag, ".dout"}, 32'(data_out), 0);
    chk({tag, ".ovf"}, 32'(overflow), 0);
    chk({tag, ".unf"}, 32'(underflow), 0);
  endtask

  initial begin
    // Fill 16, overflow write, drain 16, underflow read, idle, flush.
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 1'b0, 1'b0, 8'(i), 5'(i + 1), 8'h00, 1'b0, 1'b0,
                  (i == 15), (i + 1 >= 14), (i + 1 <= 2), 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'hFF, 5'd16, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int j = 0; j < 16; j++)
      vecs[17 + j] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'(15 - j), 8'(j), 1'b1, (j == 15),
                       1'b0, (15 - j >= 14), (15 - j <= 2), 1'b1, 1'b0};
    vecs[33] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[34] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[35] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rstn = 1'b0; flush = 0; we = 0; re = 0; data_in = '0;
    fw_flush = 0; fw_we = 0; fw_re = 0; fw_din = '0;
    #23;
    chk_reset_state("reset");
    @(negedge clk);
    rstn = 1'b1;

    for (int v = 0; v < NV; v++) begin
      cyc(vecs[v].we, vecs[v].re, vecs[v].flush, vecs[v].din);
      chk($sformatf("vec%0d.count", v), 32'(count), 32'(vecs[v].count));
      chk($sformatf("vec%0d.dout", v), 32'(data_out), 32'(vecs[v].dout));
      chk($sformatf("vec%0d.valid", v), 32'(valid), 32'(vecs[v].valid));
      chk($sformatf("vec%0d.empty", v), 32'(empty), 32'(vecs[v].empty));
      chk($sformatf("vec%0d.full", v), 32'(full), 32'(vecs[v].full));
      chk($sformatf("vec%0d.af", v), 32'(almost_full), 32'(vecs[v].af));
      chk($sformatf("vec%0d.ae", v), 32'(almost_empty), 32'(vecs[v].ae));
      chk($sformatf("vec%0d.ovf", v), 32'(overflow), 32'(vecs[v].ovf));
      chk($sformatf("vec%0d.unf", v), 32'(underflow), 32'(vecs[v].unf));
    end

    // Wrap: 10 in/out moves pointers to 10, then 16 in/out crosses the index wrap.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0);
      chk($sformatf("wrapA.dout%0d", i), 32'(data_out), 32'(8'h10 + i));
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, 8'(8'h40 + i));
      chk($sformatf("wrapB.full%0d", i), 32'(full), 32'(i == 15));
      chk($sformatf("wrapB.count%0d", i), 32'(count), 32'(i + 1));
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 0);
      chk($sformatf("wrapB.dout%0d", i), 32'(data_out), 32'(8'h40 + i));
      chk($sformatf("wrapB.valid%0d", i), 32'(valid), 1);
    end
    chk("wrapB.empty", 32'(empty), 1);

    // Simultaneous read/write at count 5, then at full.
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h60 + i));
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1, 0, 8'(8'h70 + k));
      chk($sformatf("simul.count%0d", k), 32'(count), 5);
      chk($sformatf("simul.dout%0d", k), 32'(data_out), (k < 5) ? 32'(8'h60 + k) : 32'(8'h70 + k - 5));
    end
    for (int i = 0; i < 11; i++) cyc(1, 0, 0, 8'(8'h80 + i));
    chk("simul.full", 32'(full), 1);
    cyc(1, 1, 0, 8'hEE);
    chk("simfull.count", 32'(count), 15);
    chk("simfull.ovf", 32'(overflow), 1);
    chk("simfull.valid", 32'(valid), 1);
    chk("simfull.dout", 32'(data_out), 32'h73);
    chk("simfull.full", 32'(full), 0);

    // Flush at count 9 with overflow set.
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    chk("preflush.count", 32'(count), 9);
    chk("preflush.ovf", 32'(overflow), 1);
    cyc(0, 0, 1, 0);
    chk("flush.count", 32'(count), 0);
    chk("flush.empty", 32'(empty), 1);
    chk("flush.ovf", 32'(overflow), 0);
    chk("flush.valid", 32'(valid), 0);
    chk("flush.dout", 32'(data_out), 32'h81);

    // Async reset between edges, mid-transfer.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'(8'h90 + i));
    cyc(0, 1, 0, 0);
    chk("prerst.valid", 32'(valid), 1);
    we = 1; data_in = 8'h99;
    #2 rstn = 1'b0;
    #1;
    chk_reset_state("asyncrst");
    we = 0; re = 0;
    @(negedge clk);
    rstn = 1'b1;
    cyc(1, 0, 0, 8'hC3);
    chk("postrst.count", 32'(count), 1);
    cyc(0, 1, 0, 0);
    chk("postrst.dout", 32'(data_out), 32'hC3);

    // FWFT variant.
    chk("fw.idle.valid", 32'(fw_valid), 0);
    chk("fw.idle.dout", 32'(fw_dout), 0);
    @(negedge clk);
    we = 0; re = 0; fw_we = 1; fw_din = 8'hA5;
    @(posedge clk);
    #1;
    chk("fw.wr.dout", 32'(fw_dout), 32'hA5);
    chk("fw.wr.valid", 32'(fw_valid), 1);
    @(negedge clk);
    fw_we = 0; fw_re = 1;
    @(posedge clk);
    #1;
    chk("fw.rd.valid", 32'(fw_valid), 0);
    chk("fw.rd.empty", 32'(fw_empty), 1);
    @(negedge clk);
    fw_re = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL expose parameter DEPTH, default 16, entry count; power of two, >=4.
REQ-003 The block SHALL expose parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 The block SHALL expose parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL expose parameter FWFT, default 0, output mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-008 The block SHALL have port flush  input  1  synchronous empty-the-FIFO request.
REQ-009 The block SHALL have port we  input  1  write request.
REQ-010 The block SHALL have port re  input  1  read/pop request.
REQ-011 The block SHALL have port data_in  input  WIDTH  write data.
REQ-012 The block SHALL have port data_out  output  WIDTH  read data.
REQ-013 The block SHALL have port valid  output  1  data_out qualifier.
REQ-014 The block SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 The block SHALL have ports empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-016 The block SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Pointers SHALL be $clog2(DEPTH)+1 bits; the MSB is the wrap bit, and the low bits index memory; wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-018 empty = pointers equal; full = wrap bits differ and index bits equal; count = wr_ptr - rd_ptr (modular).
REQ-019 almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL); all flags are combinational from registered state only, never from same-cycle we/re.
REQ-020 A write SHALL be accepted iff we && !full && !flush; accepted data is stored at wr_ptr and wr_ptr increments.
REQ-021 A read SHALL be accepted iff re && !empty && !flush; rd_ptr increments.
REQ-022 Acceptance SHALL use the flags at the start of the cycle: write when full is rejected even with a concurrent read, and read when empty is rejected even with a concurrent write.
REQ-023 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-024 we && full (flush low) SHALL set overflow; re && empty (flush low) SHALL set underflow; both stay set until reset or flush.
REQ-025 FWFT=0: data_out SHALL load mem[rd_ptr] on the edge of an accepted read (1-cycle latency), otherwise hold; valid SHALL pulse high exactly the cycle after each accepted read.
REQ-026 FWFT=1: data_out SHALL equal mem[rd_ptr] combinationally and valid = !empty; first written word appears the cycle after its write edge; re pops.
REQ-027 flush SHALL have priority over we/re: on that edge pointers go to 0, overflow/underflow clear, valid clears, data_out holds; memory contents are not cleared.
REQ-028 Memory storage SHALL be unreset.

Reset
REQ-029 rstn low SHALL asynchronously force pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, valid=0, data_out=0, overflow=0, underflow=0, even mid-transfer.
REQ-030 The first edge after rstn deasserts SHALL accept requests normally.

Verification (WIDTH=8, DEPTH=16, defaults)
REQ-031 Fill: 16 writes 0x00..0x0F, no reads -> full=1 after 16th edge, count=16, almost_full from count=14, 17th write sets overflow, contents unchanged.
REQ-032 Drain (FWFT=0): 16 reads after fill -> data_out 0x00..0x0F each 1 cycle after re, valid pulses, empty=1 at end, 17th read sets underflow.
REQ-033 Wrap: 10 writes/10 reads, then 16 writes/16 reads -> data order preserved across index wrap, full asserts only at count=16.
REQ-034 Simultaneous: at count=5, we&re for 8 cycles -> count stays 5; at full, we&re -> read accepted, write rejected, count=15, overflow=1.
REQ-035 FWFT=1: write 0xA5 into empty -> next cycle data_out=0xA5, valid=1; re -> valid=0 next cycle.
REQ-036 Flush/reset mid-operation: at count=9 with overflow set, flush -> count=0, empty=1, overflow=0; rstn pulse between clock edges -> all outputs to reset values immediately.
